// File: rtl/ps2_rx_fifo_if.sv
// Host-side bus of the PS/2 receiver: FIFO pop/status and sticky error flags.
// The receiver uses the slave modport; the CPU/VGA consumer uses master.
interface ps2_rx_fifo_if #(
    parameter int FIFO_DEPTH = 16
);
    logic                        iRead;
    logic                        iClearErr;
    logic [7:0]                  oData;
    logic                        oBreak;
    logic                        oExtended;
    logic                        oEmpty;
    logic                        oFull;
    logic [$clog2(FIFO_DEPTH):0] oCount;
    logic                        oParityError;
    logic                        oFrameError;
    logic                        oOverflow;

    modport slave (
        input  iRead, iClearErr,
        output oData, oBreak, oExtended, oEmpty, oFull, oCount,
        output oParityError, oFrameError, oOverflow
    );

    modport master (
        output iRead, iClearErr,
        input  oData, oBreak, oExtended, oEmpty, oFull, oCount,
        input  oParityError, oFrameError, oOverflow
    );
endinterface

// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver: pin conditioning, 11-bit deframing with timeout,
// E0/F0 prefix folding and a first-word-fall-through scancode FIFO.
module ps2_rx_fifo #(
    parameter int FILTER_LEN     = 8,
    parameter int FIFO_DEPTH     = 16,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic         iPS2_CLK,
    input  logic         iPS2_DATA,
    ps2_rx_fifo_if.slave host
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rxStateT;

    logic [1:0]    pinRaw;
    logic [1:0]    pinFilt;
    logic          filtClkPrevReg;
    logic          fallStrobe;
    logic          dataBit;

    rxStateT       stateReg, stateNext;
    logic [2:0]    bitCntReg, bitCntNext;
    logic [7:0]    shiftReg, shiftNext;
    logic          parityReg, parityNext;
    logic          extReg, extNext;
    logic          brkReg, brkNext;
    logic [TW-1:0] timeoutCntReg, timeoutCntNext;
    logic          timeoutHit;
    logic          pushReg, pushNext;
    logic [9:0]    pushWordReg, pushWordNext;
    logic          frameErrSet, parityErrSet;

    logic          parityErrReg, frameErrReg, overflowReg;

    logic [9:0]    fifoMem [FIFO_DEPTH];
    logic [AW-1:0] wrPtrReg, rdPtrReg;
    logic [CW-1:0] countReg, countNext;
    logic [9:0]    headWord;
    logic          popEn, pushEn, fifoEmpty, fifoFull;

    assign pinRaw = {iPS2_DATA, iPS2_CLK};

    // Index 0 conditions the PS/2 clock, index 1 the PS/2 data line.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : gPin
            logic [1:0]            syncReg;
            logic [FILTER_LEN-1:0] tapReg;
            logic                  filtReg;

            always_ff @(posedge Clock or negedge Reset) begin
                if (!Reset) begin
                    syncReg <= '1;
                    tapReg  <= '1;
                    filtReg <= 1'b1;
                end else begin
                    syncReg <= {syncReg[0], pinRaw[gi]};
                    tapReg  <= {tapReg[FILTER_LEN-2:0], syncReg[1]};
                    if (&tapReg) begin
                        filtReg <= 1'b1;
                    end else if (~|tapReg) begin
                        filtReg <= 1'b0;
                    end
                end
            end

            assign pinFilt[gi] = filtReg;
        end
    endgenerate

    assign fallStrobe = filtClkPrevReg & ~pinFilt[0];
    assign dataBit    = pinFilt[1];
    assign timeoutHit = (stateReg != IDLE) && (timeoutCntReg == TW'(TIMEOUT_CYCLES));

    always_comb begin
        stateNext      = stateReg;
        bitCntNext     = bitCntReg;
        shiftNext      = shiftReg;
        parityNext     = parityReg;
        extNext        = extReg;
        brkNext        = brkReg;
        pushNext       = 1'b0;
        pushWordNext   = pushWordReg;
        frameErrSet    = 1'b0;
        parityErrSet   = 1'b0;
        timeoutCntNext = (fallStrobe || stateReg == IDLE) ? '0 : timeoutCntReg + TW'(1);

        if (timeoutHit) begin
            stateNext      = IDLE;
            extNext        = 1'b0;
            brkNext        = 1'b0;
            frameErrSet    = 1'b1;
            timeoutCntNext = '0;
        end else if (fallStrobe) begin
            unique case (stateReg)
                IDLE: begin
                    if (!dataBit) begin
                        stateNext  = DATA;
                        bitCntNext = '0;
                    end else begin
                        frameErrSet = 1'b1;
                    end
                end
                DATA: begin
                    shiftNext  = {dataBit, shiftReg[7:1]};
                    bitCntNext = bitCntReg + 3'd1;
                    if (bitCntReg == 3'd7) begin
                        stateNext = PARITY;
                    end
                end
                PARITY: begin
                    parityNext = dataBit;
                    stateNext  = STOP;
                end
                STOP: begin
                    stateNext = IDLE;
                    // Stop and parity are judged independently; either kills the byte.
                    if (!dataBit || !(^{shiftReg, parityReg})) begin
                        frameErrSet  = !dataBit;
                        parityErrSet = !(^{shiftReg, parityReg});
                        extNext      = 1'b0;
                        brkNext      = 1'b0;
                    end else if (shiftReg == 8'hE0) begin
                        extNext = 1'b1;
                    end else if (shiftReg == 8'hF0) begin
                        brkNext = 1'b1;
                    end else begin
                        pushNext     = 1'b1;
                        pushWordNext = {extReg, brkReg, shiftReg};
                        extNext      = 1'b0;
                        brkNext      = 1'b0;
                    end
                end
                default: stateNext = IDLE;
            endcase
        end
    end

    assign fifoEmpty = (countReg == '0);
    assign fifoFull  = (countReg == CW'(FIFO_DEPTH));
    assign popEn     = host.iRead && !fifoEmpty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign pushEn    = pushReg && (!fifoFull || popEn);

    always_comb begin
        countNext = countReg;
        unique case ({pushEn, popEn})
            2'b10:   countNext = countReg + CW'(1);
            2'b01:   countNext = countReg - CW'(1);
            default: countNext = countReg;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (pushEn) begin
            fifoMem[wrPtrReg] <= pushWordReg;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            filtClkPrevReg <= 1'b1;
            stateReg       <= IDLE;
            bitCntReg      <= '0;
            shiftReg       <= '0;
            parityReg      <= 1'b0;
            extReg         <= 1'b0;
            brkReg         <= 1'b0;
            timeoutCntReg  <= '0;
            pushReg        <= 1'b0;
            pushWordReg    <= '0;
            parityErrReg   <= 1'b0;
            frameErrReg    <= 1'b0;
            overflowReg    <= 1'b0;
            wrPtrReg       <= '0;
            rdPtrReg       <= '0;
            countReg       <= '0;
        end else begin
            filtClkPrevReg <= pinFilt[0];
            stateReg       <= stateNext;
            bitCntReg      <= bitCntNext;
            shiftReg       <= shiftNext;
            parityReg      <= parityNext;
            extReg         <= extNext;
            brkReg         <= brkNext;
            timeoutCntReg  <= timeoutCntNext;
            pushReg        <= pushNext;
            pushWordReg    <= pushWordNext;
            countReg       <= countNext;
            if (pushEn) wrPtrReg <= wrPtrReg + AW'(1);
            if (popEn)  rdPtrReg <= rdPtrReg + AW'(1);

            // Set events take priority over a same-cycle clear.
            if (parityErrSet)            parityErrReg <= 1'b1;
            else if (host.iClearErr)     parityErrReg <= 1'b0;
            if (frameErrSet)             frameErrReg  <= 1'b1;
            else if (host.iClearErr)     frameErrReg  <= 1'b0;
            if (pushReg && !pushEn)      overflowReg  <= 1'b1;
            else if (host.iClearErr)     overflowReg  <= 1'b0;
        end
    end

    assign headWord          = fifoMem[rdPtrReg];
    assign host.oData        = fifoEmpty ? 8'h00 : headWord[7:0];
    assign host.oBreak       = fifoEmpty ? 1'b0  : headWord[8];
    assign host.oExtended    = fifoEmpty ? 1'b0  : headWord[9];
    assign host.oEmpty       = fifoEmpty;
    assign host.oFull        = fifoFull;
    assign host.oCount       = countReg;
    assign host.oParityError = parityErrReg;
    assign host.oFrameError  = frameErrReg;
    assign host.oOverflow    = overflowReg;
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Bench for ps2_rx_fifo: frame-level queue model compared every cycle it is
// settled, directed scenarios with literal expectations, then random frames.
module tb_ps2_rx_fifo;
    localparam int FILTER_LEN     = 8;
    localparam int FIFO_DEPTH     = 4;
    localparam int TIMEOUT_CYCLES = 300;
    localparam int HALF           = 20;
    localparam int SETTLE         = 30;

    logic Clock = 1'b0;
    logic Reset;
    logic ps2Clk;
    logic ps2Data;

    ps2_rx_fifo_if #(.FIFO_DEPTH(FIFO_DEPTH)) bus ();

    ps2_rx_fifo #(
        .FILTER_LEN(FILTER_LEN),
        .FIFO_DEPTH(FIFO_DEPTH),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .Clock(Clock),
        .Reset(Reset),
        .iPS2_CLK(ps2Clk),
        .iPS2_DATA(ps2Data),
        .host(bus.slave)
    );

    always #5 Clock = ~Clock;

    int nErrors = 0;
    int nChecks = 0;

    // Model: queue of {ext, brk, byte}, prefix flags, sticky flags.
    logic [9:0] mq[$];
    bit mExt, mBrk, mPar, mFrm, mOvf;
    bit modelValid = 1'b0;

    always @(negedge Clock) begin : cmp
        logic [9:0] h;
        logic [2:0] cnt;
        if (modelValid) begin
            h   = (mq.size() > 0) ? mq[0] : 10'h000;
            cnt = 3'(mq.size());
            nChecks++;
            if (bus.oData !== h[7:0] || bus.oBreak !== h[8] || bus.oExtended !== h[9] ||
                bus.oEmpty !== (mq.size() == 0) || bus.oFull !== (mq.size() == FIFO_DEPTH) ||
                bus.oCount !== cnt || bus.oParityError !== mPar ||
                bus.oFrameError !== mFrm || bus.oOverflow !== mOvf) begin
                nErrors++;
                $display("FAIL cycle_cmp t=%0t got data=%h brk=%b ext=%b empty=%b full=%b cnt=%0d par=%b frm=%b ovf=%b want data=%h brk=%b ext=%b cnt=%0d par=%b frm=%b ovf=%b",
                         $time, bus.oData, bus.oBreak, bus.oExtended, bus.oEmpty, bus.oFull,
                         bus.oCount, bus.oParityError, bus.oFrameError, bus.oOverflow,
                         h[7:0], h[8], h[9], cnt, mPar, mFrm, mOvf);
            end
        end
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic check_lit(input string name, input logic [7:0] act, input logic [7:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    function automatic void model_frame(input logic [7:0] b, input bit badPar,
                                        input bit badStop, input bit popFirst);
        logic [9:0] dropped;
        if (popFirst && mq.size() > 0) dropped = mq.pop_front();
        if (badStop) mFrm = 1'b1;
        if (badPar)  mPar = 1'b1;
        if (badStop || badPar) begin
            mExt = 1'b0;
            mBrk = 1'b0;
        end else if (b == 8'hE0) begin
            mExt = 1'b1;
        end else if (b == 8'hF0) begin
            mBrk = 1'b1;
        end else begin
            if (mq.size() < FIFO_DEPTH) mq.push_back({mExt, mBrk, b});
            else mOvf = 1'b1;
            mExt = 1'b0;
            mBrk = 1'b0;
        end
    endfunction

    // Drives the first nEdges bits of a frame (start, 8 data LSB first, parity, stop).
    task automatic send_bits(input logic [7:0] b, input bit badPar, input bit badStop,
                             input int nEdges, input int glitchBit, input bit readAtStop);
        logic [10:0] bits;
        bits = {~badStop, (~^b) ^ badPar, b, 1'b0};
        for (int i = 0; i < nEdges; i++) begin
            ps2Data = bits[i];
            if (i == glitchBit) begin
                repeat (6) tick();
                ps2Clk = 1'b0;
                repeat (3) tick();
                ps2Clk = 1'b1;
                repeat (HALF - 9) tick();
            end else begin
                repeat (HALF) tick();
            end
            ps2Clk = 1'b0;
            if (i == 10 && readAtStop) begin
                // Pop lands in the same cycle as the push of this frame's byte.
                repeat (FILTER_LEN + 4) tick();
                bus.iRead = 1'b1;
                tick();
                bus.iRead = 1'b0;
                repeat (HALF - FILTER_LEN - 5) tick();
            end else begin
                repeat (HALF) tick();
            end
            ps2Clk = 1'b1;
        end
        ps2Data = 1'b1;
    endtask

    task automatic frame(input logic [7:0] b, input bit badPar, input bit badStop,
                         input int glitchBit, input bit readAtStop);
        modelValid = 1'b0;
        send_bits(b, badPar, badStop, 11, glitchBit, readAtStop);
        repeat (SETTLE) tick();
        model_frame(b, badPar, badStop, readAtStop);
        modelValid = 1'b1;
        $display("tx frame byte=%h badPar=%0d badStop=%0d glitch=%0d readAtStop=%0d", b, badPar, badStop, glitchBit, readAtStop);
    endtask

    task automatic read_one();
        logic [9:0] w;
        bus.iRead = 1'b1;
        tick();
        bus.iRead = 1'b0;
        w = 10'h000;
        if (mq.size() > 0) w = mq.pop_front();
        $display("tx read word=%h", w);
    endtask

    task automatic clear_err();
        bus.iClearErr = 1'b1;
        tick();
        bus.iClearErr = 1'b0;
        mPar = 1'b0;
        mFrm = 1'b0;
        mOvf = 1'b0;
        $display("tx clear errors");
    endtask

    task automatic abort_frame(input logic [7:0] b);
        modelValid = 1'b0;
        send_bits(b, 1'b0, 1'b0, 5, -1, 1'b0);
        repeat (TIMEOUT_CYCLES + 10 + SETTLE) tick();
        mFrm = 1'b1;
        mExt = 1'b0;
        mBrk = 1'b0;
        modelValid = 1'b1;
        $display("tx abort after 4 data bits");
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        Reset         = 1'b0;
        ps2Clk        = 1'b1;
        ps2Data       = 1'b1;
        bus.iRead     = 1'b0;
        bus.iClearErr = 1'b0;
        repeat (3) tick();
        check_lit("reset_empty", 8'(bus.oEmpty), 8'h01);
        check_lit("reset_count", 8'(bus.oCount), 8'h00);
        check_lit("reset_data", bus.oData, 8'h00);
        Reset = 1'b1;
        modelValid = 1'b1;
        repeat (5) tick();

        // 1: single make code
        frame(8'h1C, 0, 0, -1, 0);
        check_lit("t1_data", bus.oData, 8'h1C);
        check_lit("t1_count", 8'(bus.oCount), 8'h01);
        check_lit("t1_brk", 8'(bus.oBreak), 8'h00);
        read_one();
        tick();
        check_lit("t1_empty_after", 8'(bus.oEmpty), 8'h01);
        check_lit("t1_data_after", bus.oData, 8'h00);

        // 2: prefix folding
        frame(8'hF0, 0, 0, -1, 0);
        frame(8'h1C, 0, 0, -1, 0);
        check_lit("t2_count", 8'(bus.oCount), 8'h01);
        check_lit("t2_brk", 8'(bus.oBreak), 8'h01);
        check_lit("t2_ext", 8'(bus.oExtended), 8'h00);
        frame(8'hE0, 0, 0, -1, 0);
        frame(8'hF0, 0, 0, -1, 0);
        frame(8'h75, 0, 0, -1, 0);
        read_one();
        tick();
        check_lit("t2_second", bus.oData, 8'h75);
        check_lit("t2_second_ext", 8'(bus.oExtended), 8'h01);
        read_one();

        // 3: parity error discards byte and prefix
        frame(8'h1C, 1, 0, -1, 0);
        check_lit("t3_parerr", 8'(bus.oParityError), 8'h01);
        clear_err();
        tick();
        check_lit("t3_parerr_clr", 8'(bus.oParityError), 8'h00);
        frame(8'hF0, 0, 0, -1, 0);
        frame(8'h55, 1, 0, -1, 0);
        frame(8'h1C, 0, 0, -1, 0);
        check_lit("t3_brk_cleared", 8'(bus.oBreak), 8'h00);
        read_one();
        clear_err();

        // 4: short glitch on the clock pin is filtered
        frame(8'h1C, 0, 0, 3, 0);
        check_lit("t4_data", bus.oData, 8'h1C);
        read_one();

        // 5: timeout abort
        frame(8'hF0, 0, 0, -1, 0);
        abort_frame(8'hA5);
        check_lit("t5_frmerr", 8'(bus.oFrameError), 8'h01);
        check_lit("t5_count", 8'(bus.oCount), 8'h00);
        clear_err();
        frame(8'h29, 0, 0, -1, 0);
        check_lit("t5_data", bus.oData, 8'h29);
        check_lit("t5_brk", 8'(bus.oBreak), 8'h00);
        read_one();

        // 6: overflow, then full-with-pop
        for (int i = 0; i < 5; i++) frame(8'(8'h11 + i), 0, 0, -1, 0);
        check_lit("t6_full", 8'(bus.oFull), 8'h01);
        check_lit("t6_ovf", 8'(bus.oOverflow), 8'h01);
        for (int i = 0; i < 4; i++) begin
            check_lit("t6_head", bus.oData, 8'(8'h11 + i));
            read_one();
        end
        tick();
        check_lit("t6_empty", 8'(bus.oEmpty), 8'h01);
        clear_err();
        for (int i = 0; i < 4; i++) frame(8'(8'h11 + i), 0, 0, -1, 0);
        frame(8'h15, 0, 0, -1, 1);
        check_lit("t6b_ovf", 8'(bus.oOverflow), 8'h00);
        check_lit("t6b_count", 8'(bus.oCount), 8'h04);
        for (int i = 0; i < 3; i++) read_one();
        tick();
        check_lit("t6b_last", bus.oData, 8'h15);
        read_one();

        // bad stop bit
        frame(8'h33, 0, 1, -1, 0);
        check_lit("stop_frmerr", 8'(bus.oFrameError), 8'h01);
        clear_err();

        // random traffic
        for (int n = 0; n < 24; n++) begin
            int r;
            logic [7:0] b;
            r = int'($urandom_range(0, 9));
            b = (r < 2) ? 8'hE0 : (r < 4) ? 8'hF0 : 8'($urandom_range(0, 255));
            frame(b, ($urandom_range(0, 9) == 0), ($urandom_range(0, 14) == 0),
                  ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 10)) : -1, 0);
            if ($urandom_range(0, 2) == 0) begin
                r = int'($urandom_range(0, 3));
                for (int k = 0; k < r; k++) read_one();
            end
            if ($urandom_range(0, 4) == 0) clear_err();
        end
        while (mq.size() > 0) read_one();
        read_one();
        repeat (4) tick();

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end
endmodule

// File: doc/ps2_rx_fifo.md
Name: ps2_rx_fifo

Overview:
Parametrised PS/2 keyboard receiver. It is the successor to the fixed 8-tap PS2 clock/data glitch filter and keyboard front end.
- Synchronises and debounces PS2 clock/data with a configurable filter length.
- Deframes 11-bit PS/2 frames, checks odd parity, start and stop bits, and detects stalled frames by timeout.
- Folds E0/F0 prefixes into flags and buffers decoded scancodes in a first-word-fall-through FIFO, which the CPU or VGA logic pops.

Parameters:
FILTER_LEN, 8, debounce shift-register length in Clock cycles (>=2).
FIFO_DEPTH, 16, scancode FIFO entries (power of 2, >=2).
TIMEOUT_CYCLES, 50000, Clock cycles without a PS2 falling edge before an in-progress frame is aborted.

Ports:
Clock  in  1  system clock.
Reset  in  1  asynchronous, active-low reset.
iPS2_CLK  in  1  raw PS/2 clock pin.
iPS2_DATA  in  1  raw PS/2 data pin.
iRead  in  1  pop head entry (one entry per cycle when high).
iClearErr  in  1  clears sticky error flags.
oData  out  8  head scancode (0 when empty).
oBreak  out  1  head entry was preceded by F0.
oExtended  out  1  head entry was preceded by E0.
oEmpty  out  1  FIFO empty.
oFull  out  1  FIFO full.
oCount  out  $clog2(FIFO_DEPTH)+1  entries held.
oParityError  out  1  sticky: a frame failed parity.
oFrameError  out  1  sticky: bad start bit, bad stop bit, or timeout.
oOverflow  out  1  sticky: a push was dropped because the FIFO was full.

Behaviour:
- Reset (Reset=0, async):
  - FIFO empty; oEmpty=1, oFull=0, oCount=0, oData=0, oBreak=0, oExtended=0.
  - All error flags 0; FSM in IDLE; prefix flags 0.
  - Sync and filter registers all 1; filtered clock and data =1.
- Input conditioning:
  - 2-FF synchroniser per pin, then a FILTER_LEN shift register.
  - Filtered output goes to 1 only when all taps are 1, to 0 only when all taps are 0, and otherwise holds.
  - Falling edge = filtered clock was 1 last cycle and is 0 now. It is a one-cycle strobe; filtered data is sampled on the strobe.
- Frame FSM (bits are LSB first), acting on each falling-edge strobe:
  - IDLE: data=0 -> DATA, bitcnt=0. data=1 -> stay IDLE, set oFrameError.
  - DATA: shift the bit in; after the 8th bit -> PARITY.
  - PARITY: capture the bit -> STOP.
  - STOP: always -> IDLE. Frame is good only if data=1 AND the 8 data bits plus the parity bit contain an odd number of ones.
    - Parity fail: set oParityError.
    - Stop fail: set oFrameError.
    - In either case the byte is discarded and both prefix flags are cleared.
- Timeout:
  - Counter is cleared on every strobe and whenever in IDLE; it increments otherwise.
  - On reaching TIMEOUT_CYCLES: FSM -> IDLE, oFrameError set, partial byte and prefix flags discarded.
- Prefix decode on a good byte:
  - E0: set ext flag, no push.
  - F0: set brk flag, no push.
  - Any other byte: push {ext, brk, byte}, then clear both flags.
- FIFO push timing: the push occurs in the cycle after the STOP strobe. The entry is visible, with oEmpty=0, the cycle after the push.
- FIFO rules:
  - oData, oBreak and oExtended show the head combinationally from registered storage.
  - Pop on iRead && !oEmpty; iRead when empty is ignored.
  - Push when full without a same-cycle pop: entry dropped, oOverflow set.
  - Push when full with a same-cycle pop: both occur, count unchanged.
  - Simultaneous push and pop in any other state: count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Error flags:
  - Cleared by iClearErr=1.
  - A set event in the same cycle as iClearErr wins.

Test Plan:
1. Frame 0x1C (start 0, bits 0,0,1,1,1,0,0,0, parity 0, stop 1), PS2 clock period 2000 Clock cycles -> oEmpty=0, oData=0x1C, oBreak=0, oExtended=0, oCount=1; pulse iRead -> oEmpty=1, oData=0.
2. Frames F0, 1C -> oCount=1, oData=0x1C, oBreak=1, oExtended=0. Then frames E0, F0, 75 (parity 0) -> second entry 0x75 with oBreak=1, oExtended=1, read in order.
3. Frame 0x1C with parity bit 1 -> no push, oParityError=1, oCount=0; iClearErr -> 0. Frame F0 then bad-parity frame then 0x1C -> entry has oBreak=0.
4. Glitch: 3-cycle low pulse on iPS2_CLK mid-bit with FILTER_LEN=8 -> no extra bit, frame 0x1C still received correctly.
5. Abort after 4 data bits, idle TIMEOUT_CYCLES+10 -> oFrameError=1, nothing pushed; the next good frame 0x29 is received as 0x29.
6. FIFO_DEPTH=4; send 0x11, 0x12, 0x13, 0x14, 0x15 with no reads -> oFull=1, oCount=4, oOverflow=1; four reads return 0x11..0x14, then oEmpty=1. Repeat with iRead held during the 5th push -> no overflow, 0x15 retained.
